// File: rtl/rotor_stepper.sv
// rtl/rotor_stepper.sv - Enigma rotor position controller and keystroke sequencer
// One letter per handshake: odometer step with double-step, settle wait, ciphertext capture.
module rotor_stepper #(
  parameter logic [4:0] NOTCH1        = 5'd21,
  parameter logic [4:0] NOTCH2        = 5'd4,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [4:0] key_code,
  input  logic       load,
  input  logic [4:0] init_pos1,
  input  logic [4:0] init_pos2,
  input  logic [4:0] init_pos3,
  input  logic [4:0] cipher_in,
  output logic [4:0] plain_out,
  output logic [4:0] rotate1,
  output logic [4:0] rotate2,
  output logic [4:0] rotate3,
  output logic [4:0] cipher_out,
  output logic       cipher_valid,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [4:0] r_plain;
  logic [4:0] r_rot1;
  logic [4:0] r_rot2;
  logic [4:0] r_rot3;
  logic [4:0] r_cipher;
  logic       r_cipher_valid;
  logic       r_busy;

  logic       w_key_ok;
  logic       w_cipher_ok;
  logic       w_carry2;
  logic       w_carry3;

  // Compare-and-wrap keeps every offset inside 0..25 without a modulo.
  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v >= 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [4:0] clamp_pos(input logic [4:0] v);
    return (v > 5'd25) ? 5'd0 : v;
  endfunction

  assign w_key_ok    = (key_code != 5'd0) && (key_code <= 5'd26);
  assign w_cipher_ok = (cipher_in != 5'd0) && (cipher_in <= 5'd26);
  // Rotor 2 also advances when it sits on its own notch: the double step.
  assign w_carry2    = (r_rot1 == NOTCH1) || (r_rot2 == NOTCH2);
  assign w_carry3    = (r_rot2 == NOTCH2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_plain        <= 5'd0;
      r_rot1         <= 5'd0;
      r_rot2         <= 5'd0;
      r_rot3         <= 5'd0;
      r_cipher       <= 5'd0;
      r_cipher_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_rot1 <= clamp_pos(init_pos1);
            r_rot2 <= clamp_pos(init_pos2);
            r_rot3 <= clamp_pos(init_pos3);
          end else if (key_valid && w_key_ok) begin
            r_plain <= key_code;
            r_busy  <= 1'b1;
            r_state <= S_STEP;
          end
        end
        S_STEP: begin
          r_rot1 <= inc26(r_rot1);
          if (w_carry2) r_rot2 <= inc26(r_rot2);
          if (w_carry3) r_rot3 <= inc26(r_rot3);
          r_cnt   <= SETTLE_LOAD;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_cipher       <= w_cipher_ok ? cipher_in : 5'd0;
            r_cipher_valid <= 1'b1;
            r_state        <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          r_cipher_valid <= 1'b0;
          r_busy         <= 1'b0;
          r_state        <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign plain_out    = r_plain;
  assign rotate1      = r_rot1;
  assign rotate2      = r_rot2;
  assign rotate3      = r_rot3;
  assign cipher_out   = r_cipher;
  assign cipher_valid = r_cipher_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_rotor_stepper.sv
// tb/tb_rotor_stepper.sv - self-checking bench for rotor_stepper
// Directed vector table, hand sequences for corner cases, randomized run against a model.
module tb_rotor_stepper;

  localparam int N1     = 21;
  localparam int N2     = 4;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [4:0] key_code;
  logic       load;
  logic [4:0] init_pos1, init_pos2, init_pos3;
  logic [4:0] cipher_in;
  logic [4:0] plain_out, rotate1, rotate2, rotate3, cipher_out;
  logic       cipher_valid, busy;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m1, m2, m3, mplain, mcout;

  rotor_stepper #(.NOTCH1(5'd21), .NOTCH2(5'd4), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code), .load(load),
    .init_pos1(init_pos1), .init_pos2(init_pos2), .init_pos3(init_pos3), .cipher_in(cipher_in),
    .plain_out(plain_out), .rotate1(rotate1), .rotate2(rotate2), .rotate3(rotate3),
    .cipher_out(cipher_out), .cipher_valid(cipher_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit do_load;
    int p1, p2, p3;
    int code;
    int cin;
    int e1, e2, e3;
    int ecout;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit c2, c3;
    c2 = (m1 == N1) || (m2 == N2);
    c3 = (m2 == N2);
    m1 = (m1 + 1) % 26;
    if (c2) m2 = (m2 + 1) % 26;
    if (c3) m3 = (m3 + 1) % 26;
  endtask

  task automatic do_load(input int p1, input int p2, input int p3);
    @(negedge clk);
    load = 1'b1;
    init_pos1 = 5'(p1); init_pos2 = 5'(p2); init_pos3 = 5'(p3);
    @(negedge clk);
    load = 1'b0;
    m1 = (p1 > 25) ? 0 : p1;
    m2 = (p2 > 25) ? 0 : p2;
    m3 = (p3 > 25) ? 0 : p3;
    chk("load_rot1", rotate1, m1);
    chk("load_rot2", rotate2, m2);
    chk("load_rot3", rotate3, m3);
    chk("load_busy", busy, 0);
  endtask

  // Full-timing key transaction; m* hold pre-step positions on entry.
  task automatic do_key(input int code, input int cin, input int e1, input int e2,
                        input int e3, input int ecout);
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'(code); cipher_in = 5'd31;
    @(negedge clk);
    key_valid = 1'b0;
    chk("e0_busy", busy, 1);
    chk("e0_plain", plain_out, code);
    chk("e0_rot1_unstepped", rotate1, m1);
    chk("e0_valid", cipher_valid, 0);
    @(negedge clk);
    chk("e1_rot1", rotate1, e1);
    chk("e1_rot2", rotate2, e2);
    chk("e1_rot3", rotate3, e3);
    chk("e1_valid", cipher_valid, 0);
    repeat (SETTLE - 1) begin
      @(negedge clk);
      chk("settle_valid", cipher_valid, 0);
      chk("settle_busy", busy, 1);
    end
    cipher_in = 5'(cin);
    @(negedge clk);
    chk("cap_valid", cipher_valid, 1);
    chk("cap_cout", cipher_out, ecout);
    chk("cap_busy", busy, 1);
    cipher_in = 5'd31;
    @(negedge clk);
    chk("done_valid", cipher_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_cout_hold", cipher_out, ecout);
    m1 = e1; m2 = e2; m3 = e3; mcout = ecout; mplain = code;
  endtask

  task automatic do_bad_key(input int code);
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'(code);
    @(negedge clk);
    key_valid = 1'b0;
    repeat (3) begin
      chk("bad_busy", busy, 0);
      chk("bad_valid", cipher_valid, 0);
      chk("bad_plain", plain_out, mplain);
      chk("bad_rot1", rotate1, m1);
      chk("bad_rot2", rotate2, m2);
      chk("bad_cout", cipher_out, mcout);
      @(negedge clk);
    end
  endtask

  vec_t vecs[10];

  initial begin
    int pulses;
    vecs[0] = '{1, 0, 0, 0, 1, 7, 1, 0, 0, 7};
    vecs[1] = '{1, 21, 0, 0, 2, 8, 22, 1, 0, 8};
    vecs[2] = '{1, 20, 0, 0, 3, 9, 21, 0, 0, 9};
    vecs[3] = '{1, 21, 3, 0, 4, 10, 22, 4, 0, 10};
    vecs[4] = '{0, 0, 0, 0, 5, 11, 23, 5, 1, 11};
    vecs[5] = '{0, 0, 0, 0, 26, 26, 24, 5, 1, 26};
    vecs[6] = '{1, 25, 25, 25, 6, 1, 0, 25, 25, 1};
    vecs[7] = '{1, 21, 4, 25, 7, 2, 22, 5, 0, 2};
    vecs[8] = '{1, 30, 0, 0, 8, 3, 1, 0, 0, 3};
    vecs[9] = '{0, 0, 0, 0, 9, 0, 2, 0, 0, 0};

    rst_n = 1'b0; key_valid = 1'b0; key_code = 5'd0; load = 1'b0;
    init_pos1 = 5'd0; init_pos2 = 5'd0; init_pos3 = 5'd0; cipher_in = 5'd0;
    m1 = 0; m2 = 0; m3 = 0; mplain = 0; mcout = 0;
    repeat (2) @(negedge clk);
    chk("rst_rot1", rotate1, 0);
    chk("rst_rot2", rotate2, 0);
    chk("rst_rot3", rotate3, 0);
    chk("rst_plain", plain_out, 0);
    chk("rst_cout", cipher_out, 0);
    chk("rst_valid", cipher_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].do_load) do_load(vecs[i].p1, vecs[i].p2, vecs[i].p3);
      do_key(vecs[i].code, vecs[i].cin, vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].ecout);
    end

    // key_valid during SETTLE is dropped
    do_load(3, 3, 3);
    @(negedge clk); key_valid = 1'b1; key_code = 5'd5; cipher_in = 5'd12;
    @(negedge clk); key_valid = 1'b0;
    @(negedge clk); key_valid = 1'b1; key_code = 5'd6;
    @(negedge clk); key_valid = 1'b0;
    pulses = 0;
    if (cipher_valid) pulses++;
    repeat (8) begin @(negedge clk); if (cipher_valid) pulses++; end
    model_step();
    chk("settle_drop_pulses", pulses, 1);
    chk("settle_drop_rot1", rotate1, m1);
    chk("settle_drop_plain", plain_out, 5);
    mplain = 5; mcout = 12;

    // load during STEP is ignored
    @(negedge clk); key_valid = 1'b1; key_code = 5'd7;
    @(negedge clk); key_valid = 1'b0; load = 1'b1;
    init_pos1 = 5'd10; init_pos2 = 5'd10; init_pos3 = 5'd10;
    @(negedge clk); load = 1'b0;
    repeat (4) @(negedge clk);
    model_step();
    chk("step_load_rot1", rotate1, m1);
    chk("step_load_rot2", rotate2, m2);
    chk("step_load_busy", busy, 0);
    mplain = 7;

    // load and key together: load wins
    @(negedge clk); key_valid = 1'b1; key_code = 5'd8; load = 1'b1;
    init_pos1 = 5'd17; init_pos2 = 5'd18; init_pos3 = 5'd19;
    @(negedge clk); key_valid = 1'b0; load = 1'b0;
    m1 = 17; m2 = 18; m3 = 19;
    pulses = 0;
    repeat (5) begin
      chk("ldkey_busy", busy, 0);
      if (cipher_valid) pulses++;
      @(negedge clk);
    end
    chk("ldkey_pulses", pulses, 0);
    chk("ldkey_rot1", rotate1, 17);
    chk("ldkey_rot3", rotate3, 19);

    do_bad_key(0);
    do_bad_key(27);

    // reset mid-SETTLE aborts
    @(negedge clk); key_valid = 1'b1; key_code = 5'd9;
    @(negedge clk); key_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_rot1", rotate1, 0);
    chk("abort_rot2", rotate2, 0);
    chk("abort_rot3", rotate3, 0);
    chk("abort_plain", plain_out, 0);
    chk("abort_cout", cipher_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", cipher_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin @(negedge clk); if (cipher_valid) pulses++; end
    chk("abort_pulses", pulses, 0);
    m1 = 0; m2 = 0; m3 = 0; mplain = 0; mcout = 0;
    do_key(3, 20, 1, 0, 0, 20);

    // randomized traffic against the model
    for (int it = 0; it < 150; it++) begin
      int sel, code, cin, ec, p1, p2, p3, s1, s2, s3;
      sel = $urandom_range(0, 4);
      if (sel == 0) begin
        p1 = $urandom_range(0, 31); p2 = $urandom_range(0, 31); p3 = $urandom_range(0, 31);
        if (sel == 0 && $urandom_range(0, 1) == 1) begin p1 = N1 - $urandom_range(0, 1); p2 = N2 - $urandom_range(0, 1); end
        do_load(p1, p2, p3);
      end else begin
        code = $urandom_range(0, 31);
        cin  = $urandom_range(0, 31);
        if (code >= 1 && code <= 26) begin
          s1 = m1; s2 = m2; s3 = m3;
          model_step();
          ec = (cin >= 1 && cin <= 26) ? cin : 0;
          p1 = m1; p2 = m2; p3 = m3;
          m1 = s1; m2 = s2; m3 = s3;
          do_key(code, cin, p1, p2, p3, ec);
        end else begin
          do_bad_key(code);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rotor_stepper.md
# rotor_stepper

Rotor position controller and keystroke sequencer for the Enigma datapath. Accepts one plaintext letter per handshake and advances the three rotor offsets using the Enigma odometer rule, including double-stepping. It drives the `rotate` inputs of the forward and inverse rotor stages, including rotor2_inv. After a settle window it captures the letter returned by the combinational rotor/reflector chain and presents it as ciphertext.

## Interface
- `NOTCH1`, default 5'd21: rotor 1 (fastest) position at which rotor 2 is carried.
- `NOTCH2`, default 5'd4: rotor 2 position at which rotor 3 is carried; rotor 2 also double-steps from here.
- `SETTLE_CYCLES`, default 2: cycles allowed for the combinational chain to settle; legal range 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key_valid`  in  1  one-cycle strobe: `key_code` holds a new plaintext letter.
- `key_code`  in  5  plaintext letter, A=1 … Z=26.
- `load`  in  1  one-cycle strobe: load the initial rotor positions.
- `init_pos1`, `init_pos2`, `init_pos3`  in  5 each  initial positions, 0..25.
- `cipher_in`  in  5  letter returned by the rotor chain (output of the rotor1 inverse stage), 1..26.
- `plain_out`  out  5  registered letter driven into the forward rotor 1 stage.
- `rotate1`, `rotate2`, `rotate3`  out  5 each  registered rotor offsets, 0..25.
- `cipher_out`  out  5  registered ciphertext, 1..26; 0 means invalid.
- `cipher_valid`  out  1  one-cycle strobe: `cipher_out` has been updated.
- `busy`  out  1  high from acceptance of a key until the return to IDLE.

## Operation
- **Reset values:**
  - `rotate1`, `rotate2`, `rotate3`, `plain_out` and `cipher_out` reset to 0.
  - `cipher_valid` and `busy` reset to 0.
  - State resets to IDLE.
  - Reset asserted in any state aborts the operation immediately; no `cipher_valid` is issued for the aborted key.
- **FSM:** IDLE → STEP → SETTLE → DONE → IDLE.
- **IDLE:**
  - `load` = 1: each rotor takes its `init_posN`. A value of 26..31 loads 0 for that rotor. State stays IDLE.
  - Otherwise, `key_valid` = 1 with `key_code` in 1..26: `plain_out` ← `key_code`, `busy` ← 1, go to STEP.
  - `key_code` of 0 or 27..31 is ignored; all outputs are unchanged.
  - `load` and `key_valid` in the same cycle: `load` wins and the key is dropped.
- **STEP:** all three rotors update in a single edge. Every decision uses the pre-step values.
  - Rotor 1 always steps.
  - Rotor 2 steps if `rotate1` == `NOTCH1` OR `rotate2` == `NOTCH2` (the second term is the double step).
  - Rotor 3 steps if `rotate2` == `NOTCH2`.
  - A step is +1 mod 26 (25 → 0). Arithmetic uses 5-bit compare-and-wrap; no value ≥26 is ever produced.
  - Load the settle counter with `SETTLE_CYCLES` − 1; go to SETTLE.
- **SETTLE:** the counter decrements once per cycle. On the edge where the counter is 0:
  - `cipher_in` in 1..26: `cipher_out` ← `cipher_in`.
  - `cipher_in` otherwise: `cipher_out` ← 0.
  - `cipher_valid` ← 1; go to DONE.
- **DONE:** on the next edge, `cipher_valid` ← 0, `busy` ← 0, go to IDLE.
- **Busy state:** `key_valid` and `load` are ignored in STEP, SETTLE and DONE. Dropped keys leave no side effects.
- **Hold values:**
  - `plain_out` holds the last accepted letter until the next accepted key.
  - `cipher_out` holds its value until the next capture.

## Timing
- Label the accepting edge E0:
  - E1: rotors step; new `rotate*` visible after E1.
  - E1+`SETTLE_CYCLES`: capture edge.
  - `cipher_valid` is high for exactly one cycle, after E(1+`SETTLE_CYCLES`).
  - Next edge: back in IDLE.
- `busy` rises after E0 and falls after E(2+`SETTLE_CYCLES`).
- With defaults: 4 cycles per letter. The earliest next acceptance is E5.
- `cipher_in` is sampled only on the capture edge. The chain therefore sees stable `plain_out`/`rotate*` for `SETTLE_CYCLES` full cycles.
- `load` takes effect on the sampling edge; the new positions are visible the next cycle.
- All outputs come directly from registers; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic step:** reset, positions (0,0,0), `key_valid`, `key_code`=1 → `rotate` (1,0,0) after E1. `cipher_valid` pulses once after E3, `cipher_out` = `cipher_in` sampled at E3. `busy` is high for 4 cycles.
- **Single carry:** load (21,0,0), key → (22,1,0). Load (20,0,0), key → (21,0,0) (no carry).
- **Double step:** load (21,3,0), key → (22,4,0); key → (23,5,1); key → (24,5,1).
- **Wrap:** load (25,25,25), key → (0,25,25). Load (21,4,25), key → (22,5,0). Load of `init_pos1`=30 → `rotate1`=0.
- **Dropped inputs:**
  - `key_valid` during SETTLE → no extra `cipher_valid`; positions unchanged.
  - `load` during STEP → ignored.
  - `load` + `key_valid` in the same IDLE cycle → positions loaded, no step, `busy` stays 0.
  - `key_code`=0 or 27 → ignored.
- **Reset and bad return:**
  - `rst_n` low mid-SETTLE → all outputs 0 immediately; no `cipher_valid`; a fresh key after release works.
  - `cipher_in`=0 at capture → `cipher_out`=0 with a `cipher_valid` pulse.
